// File: rtl/sseg_scan_decoder.sv
// -----------------------------------------------------------------------------
// sseg_scan_decoder
// Watches a multiplexed common-anode 7-segment bus ({an, sseg}) and recovers
// the hex digit shown on each of the four positions. A digit is captured only
// after the bus has been sampled unchanged STABLE_CYCLES times in a row with
// exactly one anode active.
//
// Optional feature macro: SSEG_SCAN_ERR_CNT_EN (adds the err_cnt output).
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   an[3:0]     anode enables, active-low (an[i]=0 selects digit i)
//   sseg[6:0]   segment lines, active-low, bit order g..a
//   digits[15:0] captured hex codes, digits[4i+3:4i] belongs to digit i
//   valid[3:0]  digit i last captured a legal hex pattern
//   blank[3:0]  digit i last captured the all-off pattern 7'h7F
//   err         one-cycle pulse when an illegal pattern is captured
//   frame_done  one-cycle pulse once all four digits have been captured
//   err_cnt[7:0] saturating count of err pulses (SSEG_SCAN_ERR_CNT_EN only)
// -----------------------------------------------------------------------------
module sseg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [6:0]  sseg,
    output logic [15:0] digits,
    output logic [3:0]  valid,
    output logic [3:0]  blank,
    output logic        err,
    output logic        frame_done
`ifdef SSEG_SCAN_ERR_CNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    localparam int unsigned AN_W   = 4;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned CODE_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Exactly one anode low -> that digit is selected.
    function automatic logic an_single(input logic [AN_W-1:0] a);
        logic ok;
        ok = 1'b0;
        case (a)
            4'hE, 4'hD, 4'hB, 4'h7: ok = 1'b1;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Registered state
    state_t                r_state;
    logic [AN_W-1:0]       r_an;
    logic [SEG_W-1:0]      r_sseg;
    logic [CNT_W-1:0]      r_cnt;
    logic [15:0]           r_digits;
    logic [3:0]            r_valid;
    logic [3:0]            r_blank;
    logic                  r_err;
    logic                  r_frame_done;
    logic [3:0]            r_mask;
`ifdef SSEG_SCAN_ERR_CNT_EN
    logic [7:0]            r_err_cnt;
`endif

    // Combinational helpers
    logic                  w_in_same;
    logic                  w_in_sel_ok;
    logic [CNT_W-1:0]      w_cnt_next;
    logic                  w_sel_ok;
    logic [1:0]            w_sel_idx;
    logic                  w_dec_legal;
    logic [CODE_W-1:0]     w_dec_code;
    logic                  w_is_blank;
    logic                  w_capture;
    logic [3:0]            w_cap_mask;

    // Stability counter: restarts on any change or on a non-single anode value.
    always_comb begin
        w_in_same   = ({an, sseg} == {r_an, r_sseg});
        w_in_sel_ok = an_single(an);
        w_cnt_next  = '0;
        if (w_in_same && w_in_sel_ok) begin
            if (r_cnt == CNT_MAX) begin
                w_cnt_next = r_cnt;
            end else begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
        end
    end

    // Digit index of the registered sample.
    always_comb begin
        w_sel_ok  = an_single(r_an);
        w_sel_idx = 2'd0;
        case (r_an)
            4'hE:    w_sel_idx = 2'd0;
            4'hD:    w_sel_idx = 2'd1;
            4'hB:    w_sel_idx = 2'd2;
            4'h7:    w_sel_idx = 2'd3;
            default: w_sel_idx = 2'd0;
        endcase
    end

    // Segment pattern to hex code.
    always_comb begin
        w_dec_legal = 1'b1;
        w_dec_code  = '0;
        case (r_sseg)
            7'h40:   w_dec_code = 4'h0;
            7'h79:   w_dec_code = 4'h1;
            7'h24:   w_dec_code = 4'h2;
            7'h30:   w_dec_code = 4'h3;
            7'h19:   w_dec_code = 4'h4;
            7'h12:   w_dec_code = 4'h5;
            7'h02:   w_dec_code = 4'h6;
            7'h78:   w_dec_code = 4'h7;
            7'h00:   w_dec_code = 4'h8;
            7'h10:   w_dec_code = 4'h9;
            7'h08:   w_dec_code = 4'hA;
            7'h03:   w_dec_code = 4'hB;
            7'h46:   w_dec_code = 4'hC;
            7'h21:   w_dec_code = 4'hD;
            7'h06:   w_dec_code = 4'hE;
            7'h0E:   w_dec_code = 4'hF;
            default: w_dec_legal = 1'b0;
        endcase
        w_is_blank = (r_sseg == SEG_BLANK);
    end

    // A saturated counter in SETTLE means STABLE_CYCLES identical samples are held.
    always_comb begin
        w_capture  = (r_state == ST_SETTLE) && w_sel_ok && (r_cnt == CNT_MAX);
        w_cap_mask = '0;
        if (w_capture) begin
            w_cap_mask[w_sel_idx] = 1'b1;
        end
    end

    // Sampler, FSM, capture and frame tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_an         <= '1;
            r_sseg       <= '1;
            r_cnt        <= '0;
            r_digits     <= '0;
            r_valid      <= '0;
            r_blank      <= '1;
            r_err        <= 1'b0;
            r_frame_done <= 1'b0;
            r_mask       <= '0;
`ifdef SSEG_SCAN_ERR_CNT_EN
            r_err_cnt    <= '0;
`endif
        end else begin
            r_an         <= an;
            r_sseg       <= sseg;
            r_cnt        <= w_cnt_next;
            r_err        <= 1'b0;
            r_frame_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_sel_ok) begin
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (!w_sel_ok) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == CNT_MAX) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // A cleared counter means the last sample differed.
                    if (r_cnt == '0) begin
                        r_state <= w_sel_ok ? ST_SETTLE : ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_capture) begin
                if (w_dec_legal) begin
                    r_digits[{w_sel_idx, 2'b00} +: CODE_W] <= w_dec_code;
                    r_valid[w_sel_idx]                     <= 1'b1;
                    r_blank[w_sel_idx]                     <= 1'b0;
                end else if (w_is_blank) begin
                    r_valid[w_sel_idx] <= 1'b0;
                    r_blank[w_sel_idx] <= 1'b1;
                end else begin
                    r_valid[w_sel_idx] <= 1'b0;
                    r_blank[w_sel_idx] <= 1'b0;
                    r_err              <= 1'b1;
`ifdef SSEG_SCAN_ERR_CNT_EN
                    if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
`endif
                end
            end

            // Full mask: pulse frame_done and restart, keeping a same-edge capture.
            if (r_mask == 4'hF) begin
                r_frame_done <= 1'b1;
                r_mask       <= w_cap_mask;
            end else begin
                r_mask <= r_mask | w_cap_mask;
            end
        end
    end

    assign digits     = r_digits;
    assign valid      = r_valid;
    assign blank      = r_blank;
    assign err        = r_err;
    assign frame_done = r_frame_done;
`ifdef SSEG_SCAN_ERR_CNT_EN
    assign err_cnt    = r_err_cnt;
`endif

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_sseg_scan_decoder
// Directed scenarios followed by randomized holds, every cycle compared with a
// run-length reference model of the digit capture rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sseg_scan_decoder;

    localparam int unsigned S = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic [3:0]  blank;
    logic        err;
    logic        frame_done;
`ifdef SSEG_SCAN_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    sseg_scan_decoder #(.STABLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .an         (an),
        .sseg       (sseg),
        .digits     (digits),
        .valid      (valid),
        .blank      (blank),
        .err        (err),
        .frame_done (frame_done)
`ifdef SSEG_SCAN_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Hex code k is shown by pattern seg_tab[k].
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state
    logic [10:0] m_prev;
    int          m_run;
    logic [15:0] m_digits;
    logic [3:0]  m_valid;
    logic [3:0]  m_blank;
    logic [3:0]  m_mask;
    logic        m_err;
    logic        m_fd;
    int          m_err_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int err_seen;
    int fd_seen;

    function automatic int single_idx(input logic [3:0] a);
        int zeros;
        int idx;
        zeros = 0;
        idx   = -1;
        for (int i = 0; i < 4; i++) begin
            if (a[i] == 1'b0) begin
                zeros++;
                idx = i;
            end
        end
        return (zeros == 1) ? idx : -1;
    endfunction

    function automatic int decode(input logic [6:0] s);
        for (int k = 0; k < 16; k++) begin
            if (seg_tab[k] == s) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_prev    = {4'hF, 7'h7F};
        m_run     = 0;
        m_digits  = 16'h0000;
        m_valid   = 4'h0;
        m_blank   = 4'hF;
        m_mask    = 4'h0;
        m_err     = 1'b0;
        m_fd      = 1'b0;
        m_err_cnt = 0;
    endtask

    // One rising edge: a digit is taken when the sample before this edge has
    // been seen exactly S times in a row with a single anode selected.
    task automatic model_edge(input logic [3:0] a, input logic [6:0] s);
        int idx;
        int code;
        logic [3:0] capbit;
        capbit = 4'h0;
        m_err  = 1'b0;
        m_fd   = (m_mask == 4'hF);
        if (m_run == S) begin
            idx = single_idx(m_prev[10:7]);
            if (idx >= 0) begin
                capbit[idx] = 1'b1;
                code = decode(m_prev[6:0]);
                if (code >= 0) begin
                    m_digits[4*idx +: 4] = 4'(code);
                    m_valid[idx] = 1'b1;
                    m_blank[idx] = 1'b0;
                end else if (m_prev[6:0] == 7'h7F) begin
                    m_valid[idx] = 1'b0;
                    m_blank[idx] = 1'b1;
                end else begin
                    m_valid[idx] = 1'b0;
                    m_blank[idx] = 1'b0;
                    m_err = 1'b1;
                    if (m_err_cnt < 255) m_err_cnt++;
                end
            end
        end
        m_mask = m_fd ? capbit : (m_mask | capbit);
        if ({a, s} == m_prev) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_run = 1;
        end
        m_prev = {a, s};
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("digits", digits, m_digits);
        chk("valid", 16'(valid), 16'(m_valid));
        chk("blank", 16'(blank), 16'(m_blank));
        chk("err", 16'(err), 16'(m_err));
        chk("frame_done", 16'(frame_done), 16'(m_fd));
`ifdef SSEG_SCAN_ERR_CNT_EN
        chk("err_cnt", 16'(err_cnt), 16'(m_err_cnt));
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_digits"}, digits, 16'h0000);
        chk({tag, "_valid"}, 16'(valid), 16'h0000);
        chk({tag, "_blank"}, 16'(blank), 16'h000F);
        chk({tag, "_err"}, 16'(err), 16'h0000);
        chk({tag, "_frame_done"}, 16'(frame_done), 16'h0000);
`ifdef SSEG_SCAN_ERR_CNT_EN
        chk({tag, "_err_cnt"}, 16'(err_cnt), 16'h0000);
`endif
    endtask

    // Drive one cycle, advance the model across the edge, compare after it.
    task automatic step(input logic [3:0] a, input logic [6:0] s);
        an   = a;
        sseg = s;
        @(posedge clk);
        model_edge(a, s);
        #1;
        if (err) err_seen++;
        if (frame_done) fd_seen++;
        check_all();
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        for (int i = 0; i < n; i++) step(a, s);
    endtask

    initial begin
        logic [3:0] ra;
        logic [6:0] rs;
        int         rn;
        int         pick;

        err_seen = 0;
        fd_seen  = 0;
        rst  = 1'b1;
        an   = 4'hF;
        sseg = 7'h7F;
        #1;
        check_reset_vals("reset");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();

        // Single digit 2 on position 0: capture on the 5th edge only.
        for (int i = 1; i <= 6; i++) begin
            step(4'hE, 7'h24);
            if (i == 4) chk("r028_not_yet_valid", 16'(valid[0]), 16'h0000);
            if (i == 5) begin
                chk("r028_valid", 16'(valid[0]), 16'h0001);
                chk("r028_digit", 16'(digits[3:0]), 16'h0002);
            end
        end

        // Full scan: 1, 3, blank, F.
        fd_seen = 0;
        hold(4'hE, 7'h79, 8);
        hold(4'hD, 7'h30, 8);
        hold(4'hB, 7'h7F, 8);
        hold(4'h7, 7'h0E, 8);
        chk("r029_digits", digits, 16'hF031);
        chk("r029_valid", 16'(valid), 16'h000B);
        chk("r029_blank", 16'(blank), 16'h0004);
        chk("r029_frame_pulses", 16'(fd_seen), 16'h0001);

        // Illegal pattern on digit 1.
        err_seen = 0;
        hold(4'hD, 7'h55, 8);
        chk("r030_err_pulses", 16'(err_seen), 16'h0001);
        chk("r030_valid1", 16'(valid[1]), 16'h0000);
        chk("r030_digit1", 16'(digits[7:4]), 16'h0003);
`ifdef SSEG_SCAN_ERR_CNT_EN
        chk("r030_err_cnt", 16'(err_cnt), 16'h0001);
`endif

        // Never stable long enough, then no or all anodes active.
        for (int i = 0; i < 6; i++) begin
            hold(4'hB, 7'h40, 3);
            hold(4'hB, 7'h79, 3);
        end
        chk("r031_toggle_digits", digits, 16'hF031);
        chk("r031_toggle_valid", 16'(valid), 16'h0009);
        hold(4'h0, 7'h40, 10);
        hold(4'hF, 7'h79, 10);
        chk("r031_an_digits", digits, 16'hF031);
        chk("r031_an_blank", 16'(blank), 16'h0004);

        // Reset on the third settle cycle, then a full settle afterwards.
        step(4'h7, 7'h00);
        step(4'h7, 7'h00);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("r032_async");
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        for (int i = 1; i <= 5; i++) begin
            step(4'h7, 7'h00);
            if (i == 4) chk("r032_not_yet", 16'(digits[15:12]), 16'h0000);
            if (i == 5) begin
                chk("r032_digit", 16'(digits[15:12]), 16'h0008);
                chk("r032_valid", 16'(valid), 16'h0008);
            end
        end

        // Randomized holds against the model.
        for (int k = 0; k < 150; k++) begin
            pick = int'($urandom_range(0, 6));
            case (pick)
                0: ra = 4'hE;
                1: ra = 4'hD;
                2: ra = 4'hB;
                3: ra = 4'h7;
                4: ra = 4'(($urandom_range(0, 1) == 0) ? 4'h0 : 4'hF);
                default: ra = 4'($urandom);
            endcase
            pick = int'($urandom_range(0, 9));
            if (pick <= 5)      rs = seg_tab[$urandom_range(0, 15)];
            else if (pick == 6) rs = 7'h7F;
            else                rs = 7'($urandom);
            rn = int'($urandom_range(1, 8));
            hold(ra, rs, rn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sseg_scan_decoder.md
SSEG_SCAN_DECODER -- requirements
Module: sseg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, number of identical consecutive samples (range 2..255) required before a digit is captured.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 an  input  4  common-anode digit enables, active-low; an[i]=0 selects digit i.
REQ-005 sseg  input  7  segment lines, active-low, bit order g..a, encoding as produced by the team's 7-segment encoder.
REQ-006 digits  output  16  captured hex codes; digits[4i+3:4i] belongs to digit i.
REQ-007 valid  output  4  valid[i]=1 when digit i last captured a legal hex pattern.
REQ-008 blank  output  4  blank[i]=1 when digit i last captured the all-off pattern 7'h7F.
REQ-009 err  output  1  one-cycle pulse on capture of an illegal pattern.
REQ-010 frame_done  output  1  one-cycle pulse when all four digits captured since the last pulse.

Function
REQ-011 Input pair {an, sseg} registered every clock into a sample register; comparison against the previous sample drives a stability counter (8 bits).
REQ-012 Counter clears to 0 when the new sample differs from the previous one; otherwise increments, saturating at STABLE_CYCLES-1.
REQ-013 States: IDLE (no single digit selected), SETTLE (one digit selected, counting), HOLD (captured, waiting for change).
REQ-014 IDLE->SETTLE when sampled an has exactly one zero bit; any other an value (0, 2+ active, all inactive) keeps/returns the FSM in IDLE with counter cleared and no capture.
REQ-015 SETTLE->HOLD when STABLE_CYCLES identical consecutive samples exist; capture occurs on that edge, so outputs reflect a new stable input exactly STABLE_CYCLES+1 rising edges after it is applied.
REQ-016 SETTLE restarts counting (stays SETTLE) on any sample change that still selects a single digit; goes to IDLE otherwise.
REQ-017 HOLD->SETTLE (or IDLE per REQ-014) on any sample change; no second capture while input stays unchanged.
REQ-018 Decode table (sseg->code): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
REQ-019 Legal pattern: digits field <= code, valid[i]<=1, blank[i]<=0.
REQ-020 Pattern 7'h7F: digits field unchanged, valid[i]<=0, blank[i]<=1.
REQ-021 Any other pattern: digits field unchanged, valid[i]<=0, blank[i]<=0, err pulses 1 cycle on the capture edge.
REQ-022 A per-digit captured mask records each capture (legal, blank or illegal); when the mask becomes all ones, frame_done pulses on the following edge and the mask clears on that same edge; a capture on that edge sets its bit in the cleared mask.
REQ-023 Recapture of an already-marked digit before frame completion updates its outputs and leaves the mask unchanged.

Reset
REQ-024 On rst=1, immediately: FSM=IDLE, counter=0, sample registers=all ones, digits=16'h0000, valid=4'h0, blank=4'hF, err=0, frame_done=0, mask=0, error counter=0.
REQ-025 Reset asserted mid-SETTLE aborts the capture; first capture after release requires a full STABLE_CYCLES settle.

Configuration
REQ-026 Macro SSEG_SCAN_ERR_CNT_EN: when defined, adds output err_cnt (8 bits) counting err pulses, saturating at 8'hFF, cleared only by rst.
REQ-027 Without SSEG_SCAN_ERR_CNT_EN: port err_cnt and its counter absent; all other behaviour identical.

Verification
REQ-028 an=4'hE, sseg=7'h24 held 6 cycles, STABLE_CYCLES=4 -> digits[3:0]=2, valid[0]=1 exactly 5 edges after apply; single capture only.
REQ-029 Scan digits 0..3 with 7'h79,7'h30,7'h7F,7'h0E, 8 cycles each -> digits=16'hF?31 (digit2 unchanged), valid=4'b1011, blank=4'b0100, frame_done one pulse after the fourth capture.
REQ-030 an=4'hD, sseg=7'h55 held 8 cycles -> err single pulse, valid[1]=0, digits[7:4] unchanged; with SSEG_SCAN_ERR_CNT_EN err_cnt=1.
REQ-031 sseg toggles 7'h40/7'h79 every 3 cycles on an=4'hB -> no capture, digits unchanged; an=4'h0 or 4'hF held 10 cycles -> no capture.
REQ-032 rst asserted on the 3rd settle cycle of an=4'h7, sseg=7'h00 -> outputs at reset values asynchronously; after release capture of 8 after STABLE_CYCLES+1 edges.
